// File: rtl/enigma_out_formatter.sv
`default_nettype none
// ============================================================================
// Module      : enigma_out_formatter
// Description : Buffers coded letters from the Enigma core and turns them into
//               an ASCII byte stream. A space goes between groups of GROUP_LEN
//               letters and a newline ends each message. The output is a
//               registered valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_out_formatter #(
  parameter int DEPTH     = 16,
  parameter int GROUP_LEN = 5,
  parameter bit LOWER     = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [6:0]               symb_i,
  input  logic                     symb_val_i,
  input  logic                     msg_end_i,
  output logic [7:0]               data_o,
  output logic                     val_o,
  input  logic                     rdy_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic                     bad_symb_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
  localparam logic [3:0]    c_group_len = 4'(GROUP_LEN);
  localparam logic [7:0]    c_base      = LOWER ? 8'h61 : 8'h41;
  localparam logic [7:0]    c_space     = 8'h20;
  localparam logic [7:0]    c_newline   = 8'h0A;

  // LETTER is part of the state set, but letters are presented directly from
  // IDLE so that back-to-back letters sustain one byte per clock.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LETTER  = 2'd1,
    ST_SPACE   = 2'd2,
    ST_NEWLINE = 2'd3
  } state_t;

  // FIFO entry layout: {end_flag, let_flag, idx[4:0]}
  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nxt;
  logic          r_val;
  logic          w_val_nxt;
  logic [3:0]    r_grp;
  logic [3:0]    w_grp_nxt;
  logic [4:0]    r_ret_idx;
  logic [4:0]    w_ret_idx_nxt;
  logic          r_ret_end;
  logic          w_ret_end_nxt;
  logic          r_ovf;
  logic          r_bad;

  logic          w_legal;
  logic          w_let;
  logic          w_wr_req;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_xfer;
  logic          w_out_free;
  logic [6:0]    w_head;
  logic          w_head_end;
  logic          w_head_let;
  logic [4:0]    w_head_idx;

  function automatic logic [7:0] f_ascii(input logic [4:0] idx);
    return c_base + {3'b000, idx} - 8'd1;
  endfunction

  assign w_legal    = (symb_i >= 7'd1) && (symb_i <= 7'd26);
  assign w_let      = symb_val_i && w_legal;
  // An illegal letter alone writes nothing; with an end marker the marker survives.
  assign w_wr_req   = w_let || msg_end_i;
  assign w_full     = (r_level == c_depth);
  assign w_empty    = (r_level == '0);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign w_wr       = w_wr_req && !w_full;
  assign w_xfer     = r_val && rdy_i;
  assign w_out_free = !r_val || rdy_i;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_end = w_head[6];
  assign w_head_let = w_head[5];
  assign w_head_idx = w_head[4:0];

  // Next-state and output-register decode; defaults hold state and retire a transferred byte.
  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_val_nxt     = r_val && !rdy_i;
    w_grp_nxt     = r_grp;
    w_ret_idx_nxt = r_ret_idx;
    w_ret_end_nxt = r_ret_end;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_out_free) begin
          w_pop     = 1'b1;
          w_val_nxt = 1'b1;
          if (w_head_let) begin
            if (r_grp == c_group_len) begin
              // Group boundary: space first, the letter waits in the retain register.
              w_data_nxt    = c_space;
              w_ret_idx_nxt = w_head_idx;
              w_ret_end_nxt = w_head_end;
              w_state_nxt   = ST_SPACE;
            end else begin
              w_data_nxt = f_ascii(w_head_idx);
              w_grp_nxt  = r_grp + 4'd1;
              if (w_head_end) begin
                w_state_nxt = ST_NEWLINE;
              end
            end
          end else begin
            w_data_nxt = c_newline;
            w_grp_nxt  = 4'd0;
          end
        end
      end
      ST_SPACE: begin
        if (w_xfer) begin
          w_data_nxt  = f_ascii(r_ret_idx);
          w_val_nxt   = 1'b1;
          w_grp_nxt   = 4'd1;
          w_state_nxt = r_ret_end ? ST_NEWLINE : ST_IDLE;
        end
      end
      ST_NEWLINE: begin
        if (w_xfer) begin
          w_data_nxt  = c_newline;
          w_val_nxt   = 1'b1;
          w_grp_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {msg_end_i, w_let, symb_i[4:0]};
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_wr_req && w_full) begin
        r_ovf <= 1'b1;
      end
      if (symb_val_i && !w_legal) begin
        r_bad <= 1'b1;
      end
    end
  end

  // FSM state, output register, group counter and retained letter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_data    <= 8'h00;
      r_val     <= 1'b0;
      r_grp     <= 4'd0;
      r_ret_idx <= 5'd0;
      r_ret_end <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_val     <= w_val_nxt;
      r_grp     <= w_grp_nxt;
      r_ret_idx <= w_ret_idx_nxt;
      r_ret_end <= w_ret_end_nxt;
    end
  end

  assign data_o     = r_data;
  assign val_o      = r_val;
  assign level_o    = r_level;
  assign ovf_o      = r_ovf;
  assign bad_symb_o = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_enigma_out_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_out_formatter
// Description : Self-checking bench for enigma_out_formatter: directed
//               scenarios followed by a randomized run against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enigma_out_formatter;

  localparam int DEPTH = 16;
  localparam int GLEN  = 5;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] symb_i = '0;
  logic       symb_val_i = 1'b0;
  logic       msg_end_i = 1'b0;
  logic [7:0] data_o;
  logic       val_o;
  logic       rdy_i = 1'b1;
  logic [4:0] level_o;
  logic       ovf_o;
  logic       bad_symb_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         m_cnt = 0;

  enigma_out_formatter #(
    .DEPTH     (DEPTH),
    .GROUP_LEN (GLEN),
    .LOWER     (1'b0)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .symb_i     (symb_i),
    .symb_val_i (symb_val_i),
    .msg_end_i  (msg_end_i),
    .data_o     (data_o),
    .val_o      (val_o),
    .rdy_i      (rdy_i),
    .level_o    (level_o),
    .ovf_o      (ovf_o),
    .bad_symb_o (bad_symb_o)
  );

  always #5 clk_i = ~clk_i;

  // Capture every byte that will be accepted at the coming rising edge.
  always @(negedge clk_i) begin
    if (!rst_i && val_o && rdy_i) got.push_back(data_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [6:0] s, input logic v, input logic e);
    symb_i     = s;
    symb_val_i = v;
    msg_end_i  = e;
  endtask

  task automatic feed(input logic [6:0] s, input logic v, input logic e);
    drive(s, v, e);
    tick();
    drive(7'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endtask

  // Reference formatter: lazy spaces before a letter that starts a new group.
  task automatic m_push(input int s, input bit v, input bit e);
    if (v && s >= 1 && s <= 26) begin
      if (m_cnt == GLEN) begin
        exp_q.push_back(8'h20);
        m_cnt = 0;
      end
      exp_q.push_back(8'(8'h40 + s));
      m_cnt++;
    end
    if (e) begin
      exp_q.push_back(8'h0A);
      m_cnt = 0;
    end
  endtask

  task automatic drain();
    int idle_n = 0;
    int budget = 0;
    rdy_i = 1'b1;
    drive(7'd0, 1'b0, 1'b0);
    while (idle_n < 3 && budget < 600) begin
      tick();
      budget++;
      if (!val_o && level_o == 5'd0) idle_n++;
      else idle_n = 0;
    end
    if (idle_n < 3) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] held;
    bit any_bad;
    int k;
    int s;
    bit v;
    bit e;

    // Reset state
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_data", data_o, 8'h00);
    chk("rst_val", val_o, 1'b0);
    chk("rst_level", level_o, 5'd0);
    chk("rst_ovf", ovf_o, 1'b0);
    chk("rst_bad", bad_symb_o, 1'b0);

    // Test 1: six letters, 2-cycle latency, space after five
    drive(7'd1, 1'b1, 1'b0);
    tick();
    chk("t1_val_k", val_o, 1'b0);
    chk("t1_level_k", level_o, 5'd1);
    drive(7'd2, 1'b1, 1'b0);
    tick();
    chk("t1_val_k1", val_o, 1'b1);
    chk("t1_data_k1", data_o, 8'h41);
    for (int i = 3; i <= 6; i++) feed(7'(i), 1'b1, 1'b0);
    drain();
    expect_str("ABCDE F");
    cmp_stream("t1");

    // Test 2: short message, newline resets grouping
    feed(7'd26, 1'b1, 1'b0);
    feed(7'd1, 1'b1, 1'b0);
    feed(7'd0, 1'b0, 1'b1);
    repeat (3) tick();
    for (int i = 2; i <= 7; i++) feed(7'(i), 1'b1, 1'b0);
    feed(7'd0, 1'b0, 1'b1);
    drain();
    expect_str("ZA\nBCDEF G\n");
    cmp_stream("t2");

    // Test 3: overflow with sink stalled, output held
    rdy_i = 1'b0;
    for (int i = 1; i <= 20; i++) feed(7'(i), 1'b1, 1'b0);
    repeat (2) tick();
    chk("t3_level", level_o, 5'd16);
    chk("t3_ovf", ovf_o, 1'b1);
    chk("t3_val", val_o, 1'b1);
    chk("t3_data", data_o, 8'h41);
    held = data_o;
    repeat (5) tick();
    chk("t3_hold", data_o, held);
    chk("t3_level_hold", level_o, 5'd16);
    drain();
    expect_str("ABCDE FGHIJ KLMNO PQ");
    cmp_stream("t3");
    chk("t3_ovf_sticky", ovf_o, 1'b1);

    // Test 4: illegal symbols
    chk("t4_bad_before", bad_symb_o, 1'b0);
    feed(7'd0, 1'b1, 1'b0);
    feed(7'd27, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t4_bad", bad_symb_o, 1'b1);
    chk("t4_val", val_o, 1'b0);
    chk("t4_level", level_o, 5'd0);
    feed(7'd0, 1'b1, 1'b1);
    drain();
    expect_str("\n");
    cmp_stream("t4");

    // Test 5: letter with end marker at a full group
    for (int i = 1; i <= 5; i++) feed(7'(i), 1'b1, 1'b0);
    feed(7'd3, 1'b1, 1'b1);
    drain();
    expect_str("ABCDE C\n");
    cmp_stream("t5");

    // Test 6: reset mid-transfer
    rdy_i = 1'b0;
    for (int i = 1; i <= 8; i++) feed(7'(i), 1'b1, 1'b0);
    chk("t6_level_pre", level_o, 5'd7);
    chk("t6_val_pre", val_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_val", val_o, 1'b0);
    chk("t6_level", level_o, 5'd0);
    chk("t6_ovf", ovf_o, 1'b0);
    chk("t6_bad", bad_symb_o, 1'b0);
    chk("t6_data", data_o, 8'h00);
    got.delete();
    rdy_i = 1'b1;
    for (int i = 1; i <= 6; i++) feed(7'(i), 1'b1, 1'b0);
    drain();
    expect_str("ABCDE F");
    cmp_stream("t6");

    // Randomized run: random sink stalls, legal/illegal letters, end markers
    feed(7'd0, 1'b0, 1'b1);
    m_cnt = 0;
    expect_str("\n");
    any_bad = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rdy_i = ($urandom_range(0, 3) != 0);
      if (level_o <= 5'(DEPTH - 2) && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 19);
        if (k == 19) begin
          s = 0; v = 1'b0; e = 1'b1;
        end else begin
          if (k == 0) s = 0;
          else if (k == 1) s = $urandom_range(27, 127);
          else s = $urandom_range(1, 26);
          v = 1'b1;
          e = ($urandom_range(0, 7) == 0);
        end
        if (v && (s < 1 || s > 26)) any_bad = 1'b1;
        drive(7'(s), v, e);
        m_push(s, v, e);
      end else begin
        drive(7'd0, 1'b0, 1'b0);
      end
      tick();
    end
    drain();
    chk("rnd_ovf", ovf_o, 1'b0);
    chk("rnd_bad", bad_symb_o, any_bad);
    cmp_stream("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
